// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial-in / byte-out signal bundle for uart_rx
//
// Purpose: groups the serial line input and the received-byte outputs of
//          uart_rx so the receiver and its consumer share one connection.
// Signals:
//   i_rx          serial line, idle high, asynchronous to the receiver clock
//   o_data        last good byte received
//   o_data_valid  one-cycle pulse, o_data is valid this cycle
//   o_frame_err   one-cycle pulse, stop bit sampled low
//   o_busy        receiver is inside a frame (or waiting out a break)
//   o_parity_err  one-cycle pulse with o_data_valid when even parity fails
//                 (present only when UART_RX_PARITY_EN is defined)
// Modports:
//   slave   the receiver (uart_rx)
//   master  the line driver / byte consumer
interface uart_rx_if;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_data_valid;
   logic       o_frame_err;
   logic       o_busy;
`ifdef UART_RX_PARITY_EN
   logic       o_parity_err;
`endif

`ifdef UART_RX_PARITY_EN
   modport slave (
      input  i_rx,
      output o_data, o_data_valid, o_frame_err, o_busy, o_parity_err
   );
   modport master (
      output i_rx,
      input  o_data, o_data_valid, o_frame_err, o_busy, o_parity_err
   );
`else
   modport slave (
      input  i_rx,
      output o_data, o_data_valid, o_frame_err, o_busy
   );
   modport master (
      output i_rx,
      input  o_data, o_data_valid, o_frame_err, o_busy
   );
`endif
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - asynchronous serial receiver, 8N1 (8E1 with parity option)
//
// Purpose: receives frames on an idle-high serial line and presents each
//          good byte as a one-cycle valid pulse. No buffering; the consumer
//          must capture o_data in the cycle o_data_valid is high.
// Configuration macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames, no parity state, no o_parity_err signal
//   defined   : 8E1 frames, parity bit sampled between data and stop,
//               o_parity_err pulses alongside o_data_valid on a parity miss
// Parameters:
//   CLKS_PER_BIT  i_clk cycles per serial bit (>= 4)
//   CNT_W         bit-period counter width (2**CNT_W > CLKS_PER_BIT)
// Ports:
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   rx_if.slave   i_rx in; o_data, o_data_valid, o_frame_err, o_busy
//                 (and o_parity_err) out
module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int CNT_W        = 16
) (
   input  logic    i_clk,
   input  logic    i_rst,
   uart_rx_if.slave rx_if
);

   // Start bit is checked at its middle; from there each full bit period
   // lands on the middle of the next bit.
   localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      S_PARITY = 3'd5
`endif
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif

   logic rx_s;
   assign rx_s = sync2_q;

   always_comb begin
      sync1_d = rx_if.i_rx;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  // Line went back high before mid start bit: a glitch.
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  idx_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         S_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  // Even parity: parity bit must equal XOR of the data bits.
                  perr_d  = par_q ^ (^shift_q);
`endif
                  // Leaving at mid stop bit lets an immediately following
                  // start bit be caught with no idle gap.
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_BREAK: begin
            // A line held low must not be read as a stream of zero frames.
            cnt_d = '0;
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx_if.o_data       = data_q;
   assign rx_if.o_data_valid = valid_q;
   assign rx_if.o_frame_err  = ferr_q;
   assign rx_if.o_busy       = busy_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int CPB  = 8;
   localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   uart_rx_if rx_if();

   uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .rx_if (rx_if)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   logic [7:0] rx_q[$];
   int         valid_cyc[$];
   int         valid_cnt = 0;
   int         ferr_cnt = 0;
   int         overlap_cnt = 0;
   int         long_cnt = 0;
   int         perr_cnt = 0;
   int         perr_with_valid = 0;
   logic       prev_v = 1'b0;
   logic       prev_f = 1'b0;

   always @(negedge i_clk) begin
      if (rx_if.o_data_valid === 1'b1) begin
         rx_q.push_back(rx_if.o_data);
         valid_cyc.push_back(cyc);
         valid_cnt <= valid_cnt + 1;
      end
      if (rx_if.o_frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (rx_if.o_data_valid === 1'b1 && rx_if.o_frame_err === 1'b1)
         overlap_cnt <= overlap_cnt + 1;
      if ((rx_if.o_data_valid === 1'b1 && prev_v) || (rx_if.o_frame_err === 1'b1 && prev_f))
         long_cnt <= long_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (rx_if.o_parity_err === 1'b1) begin
         perr_cnt <= perr_cnt + 1;
         if (rx_if.o_data_valid === 1'b1) perr_with_valid <= perr_with_valid + 1;
      end
`endif
      prev_v <= (rx_if.o_data_valid === 1'b1);
      prev_f <= (rx_if.o_frame_err === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input int n);
      rx_if.i_rx = v;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive(par, CPB);
`else
      if (par) begin end
`endif
      drive(stop, CPB);
   endtask

   logic [7:0] b;

   initial begin
      rx_if.i_rx = 1'b1;
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      check("rst_data",  {24'd0, rx_if.o_data}, 32'h00);
      check("rst_valid", {31'd0, rx_if.o_data_valid}, 32'd0);
      check("rst_ferr",  {31'd0, rx_if.o_frame_err}, 32'd0);
      check("rst_busy",  {31'd0, rx_if.o_busy}, 32'd0);
      i_rst = 1'b0;
      drive(1'b1, 4);

      // 0xA5, with busy probes inside the frame.
      b = 8'hA5;
      drive(1'b0, 4);
      check("a5_busy_start", {31'd0, rx_if.o_busy}, 32'd1);
      drive(1'b0, CPB - 4);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      check("a5_busy_mid", {31'd0, rx_if.o_busy}, 32'd1);
      for (int i = 4; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive(1'b0, CPB);
`endif
      drive(1'b1, CPB);
      drive(1'b1, 4);
      check("a5_valid_cnt", valid_cnt, 32'd1);
      check("a5_data", {24'd0, rx_q[0]}, 32'hA5);
      check("a5_ferr_cnt", ferr_cnt, 32'd0);
      check("a5_busy_end", {31'd0, rx_if.o_busy}, 32'd0);

      // Back-to-back 0x00 then 0xFF, no idle gap.
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      drive(1'b1, 4);
      check("b2b_valid_cnt", valid_cnt, 32'd3);
      check("b2b_data0", {24'd0, rx_q[1]}, 32'h00);
      check("b2b_data1", {24'd0, rx_q[2]}, 32'hFF);
      check("b2b_spacing", valid_cyc[2] - valid_cyc[1], FRAME_BITS * CPB);
      check("b2b_ferr_cnt", ferr_cnt, 32'd0);

      // Two-cycle low glitch on an idle line.
      drive(1'b0, 2);
      drive(1'b1, HALF + 3);
      check("glitch_busy", {31'd0, rx_if.o_busy}, 32'd0);
      drive(1'b1, CPB);
      check("glitch_valid_cnt", valid_cnt, 32'd3);
      check("glitch_ferr_cnt", ferr_cnt, 32'd0);

      // 0x3C with stop bit low, then line held low.
      b = 8'h3C;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive(1'b0, CPB);
`endif
      drive(1'b0, CPB);
      drive(1'b0, 40);
      check("brk_ferr_cnt", ferr_cnt, 32'd1);
      check("brk_busy_low", {31'd0, rx_if.o_busy}, 32'd1);
      check("brk_data_kept", {24'd0, rx_if.o_data}, 32'hFF);
      check("brk_valid_cnt", valid_cnt, 32'd3);
      drive(1'b1, 5);
      check("brk_busy_release", {31'd0, rx_if.o_busy}, 32'd0);
      drive(1'b1, CPB);
      check("brk_ferr_after", ferr_cnt, 32'd1);
      check("brk_valid_after", valid_cnt, 32'd3);

      // Reset during data bit 4 of 0x5A, then 0x81.
      b = 8'h5A;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      drive(b[4], 4);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("rst_mid_busy", {31'd0, rx_if.o_busy}, 32'd0);
      check("rst_mid_data", {24'd0, rx_if.o_data}, 32'h00);
      i_rst = 1'b0;
      drive(1'b1, CPB);
      check("rst_mid_no_pulse", valid_cnt, 32'd3);
      send_frame(8'h81, 1'b0, 1'b1);
      drive(1'b1, 4);
      check("post_rst_valid_cnt", valid_cnt, 32'd4);
      check("post_rst_data", {24'd0, rx_q[3]}, 32'h81);
      check("post_rst_ferr_cnt", ferr_cnt, 32'd1);

`ifdef UART_RX_PARITY_EN
      // 0x07 has odd weight; parity 0 is wrong, parity 1 is right.
      send_frame(8'h07, 1'b0, 1'b1);
      drive(1'b1, 4);
      check("par_bad_valid_cnt", valid_cnt, 32'd5);
      check("par_bad_data", {24'd0, rx_q[4]}, 32'h07);
      check("par_bad_perr_cnt", perr_cnt, 32'd1);
      check("par_bad_with_valid", perr_with_valid, 32'd1);
      send_frame(8'h07, 1'b1, 1'b1);
      drive(1'b1, 4);
      check("par_good_valid_cnt", valid_cnt, 32'd6);
      check("par_good_data", {24'd0, rx_q[5]}, 32'h07);
      check("par_good_perr_cnt", perr_cnt, 32'd1);
`endif

      check("pulse_overlap", overlap_cnt, 32'd0);
      check("pulse_width", long_cnt, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
